// File: rtl/pc_pkg.sv
// pc_pkg: shared program-counter width, reset vector and PC type
// Contents: PC_WIDTH, PC_RESET_VECTOR, pc_t
package pc_pkg;
  localparam int PC_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 32'h0;
  typedef logic [PC_WIDTH-1:0] pc_t;
endpackage

// File: rtl/pc.sv
// pc: program counter register with synchronous reset and load enable
// Ports: Clock_in (rising-edge clock), Signal_reset (sync, active-high),
//        In (next PC), Signal_write (load enable), Data (current PC, registered)
// Macro PC_MISALIGN_FLAG_EN adds Misaligned, registered alongside Data
module pc
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             Clock_in,
  input  logic             Signal_reset,
  input  logic [WIDTH-1:0] In,
  input  logic             Signal_write,
`ifdef PC_MISALIGN_FLAG_EN
  output logic             Misaligned,
`endif
  output logic [WIDTH-1:0] Data
);
  always_ff @(posedge Clock_in)
    if (Signal_reset) Data <= RESET_VALUE;
    else if (Signal_write) Data <= In;
`ifdef PC_MISALIGN_FLAG_EN
  always_ff @(posedge Clock_in)
    if (Signal_reset) Misaligned <= |RESET_VALUE[1:0];
    else if (Signal_write) Misaligned <= |In[1:0];
`endif
endmodule

// File: tb/tb_pc.sv
// tb_pc: randomized scoreboard bench for the pc register
module tb_pc;
  typedef struct packed {
    logic        mis;
    logic [31:0] data;
  } exp_t;
  logic        clk = 1'b0;
  logic        Signal_reset = 1'b0;
  logic        Signal_write = 1'b0;
  logic [31:0] In = '0;
  logic [31:0] Data;
`ifdef PC_MISALIGN_FLAG_EN
  logic        Misaligned;
`endif
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t last;
  bit have_last = 0;
  logic [31:0] mdl_pc = '0;
  bit mdl_mis = 0;
  pc dut (
    .Clock_in(clk),
    .Signal_reset(Signal_reset),
    .In(In),
    .Signal_write(Signal_write),
`ifdef PC_MISALIGN_FLAG_EN
    .Misaligned(Misaligned),
`endif
    .Data(Data)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction
  task automatic step(bit rst, bit wr, logic [31:0] din, bit glitch);
    @(negedge clk);
    Signal_write = wr;
    In = din;
    if (glitch) begin
      Signal_reset = 1'b1;
      #2;
    end
    Signal_reset = rst;
    if (rst) begin
      mdl_pc = 32'h0;
      mdl_mis = 0;
    end else if (wr) begin
      mdl_pc = din;
      mdl_mis = (din % 4) != 0;
    end
    sb.push_back('{mis: mdl_mis, data: mdl_pc});
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      last = sb.pop_front();
      have_last = 1;
      chk("data_after_edge", Data, last.data);
`ifdef PC_MISALIGN_FLAG_EN
      chk("misaligned_after_edge", {31'b0, Misaligned}, {31'b0, last.mis});
`endif
    end
  end
  initial forever begin
    @(negedge clk);
    #1;
    if (have_last) chk("data_stable_mid_cycle", Data, last.data);
  end
  initial begin
    step(0, 1, 32'h0000_0000, 0);
    step(0, 0, 32'h0000_001F, 0);
    step(0, 1, 32'hF000_000F, 0);
    step(0, 1, 32'h0000_0000, 0);
    step(1, 0, 32'h0000_000F, 0);
    step(1, 1, 32'h0000_000F, 0);
    step(0, 1, 32'h8000_0003, 0);
    step(1, 0, 32'h0000_001F, 0);
    step(0, 1, 32'h8000_0003, 0);
    step(0, 1, 32'h0000_0004, 0);
    step(0, 1, 32'h1234_5679, 1);
    step(1, 0, 32'h0000_0000, 0);
    step(0, 1, 32'hFFFF_FFFF, 0);
    step(0, 0, 32'h0000_0000, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(9) == 0, $urandom_range(1) == 1, $urandom, $urandom_range(7) == 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
